checksum_verify: RTL and testbench

- Receive-side counterpart of the `checksum` block.
- `checksum` produces codeword = data × polynomial (17-bit × 4-bit → 21-bit). This block divides a received codeword by the same polynomial to recover the data word and a remainder.
- It flags corruption (non-zero remainder), a zero polynomial, or quotient overflow.
- It is an iterative shift-subtract divider, one quotient bit per clock, with a valid/ready input handshake.

---
 rtl/checksum_pkg.sv | 19 +
 rtl/checksum_div_step.sv | 33 +++
 rtl/checksum_verify.sv | 142 ++++++++++++++
 tb/tb_checksum_verify.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/checksum_pkg.sv
// checksum_pkg
//   Shared definitions for the checksum encoder and checksum_verify decoder:
//   codeword/data/polynomial widths, the divider state type and the width of
//   the divider iteration counter.
package checksum_pkg;

    localparam int IN_DATA_WIDTH  = 21;  // codeword (dividend) width
    localparam int OUT_DATA_WIDTH = 17;  // recovered data (quotient) width
    localparam int POLY_WIDTH     = 4;   // polynomial (divisor) / remainder width

    localparam int CNT_WIDTH = $clog2(IN_DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/checksum_div_step.sv
// checksum_div_step
//   One restoring-division step: shifts the next dividend bit into the
//   partial remainder and subtracts the divisor when it fits.
// Ports:
//   rem_i     : current partial remainder (always < divisor)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor
//   rem_o     : new partial remainder
//   q_o       : quotient bit produced by this step
module checksum_div_step
    import checksum_pkg::*;
#(
    parameter int POLY_WIDTH = checksum_pkg::POLY_WIDTH
) (
    input  logic [POLY_WIDTH-1:0] rem_i,
    input  logic                  bit_i,
    input  logic [POLY_WIDTH-1:0] divisor_i,
    output logic [POLY_WIDTH-1:0] rem_o,
    output logic                  q_o
);

    logic [POLY_WIDTH:0] shifted;
    logic [POLY_WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        q_o     = (shifted >= {1'b0, divisor_i});
        // The result is always < divisor, so the top bit is known zero.
        rem_o   = POLY_WIDTH'(q_o ? diff : shifted);
    end

endmodule

// File: rtl/checksum_verify.sv
// checksum_verify
//   Receive-side checker for the checksum encoder: divides a received
//   codeword by the polynomial (one quotient bit per clock) and reports the
//   recovered data, the remainder and an error flag.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   in_data_vld  : codeword valid (accepted when in_ready is high)
//   in_data      : received codeword
//   polynomial   : divisor
//   in_ready     : high only while idle
//   out_data     : recovered data (low OUT_DATA_WIDTH quotient bits)
//   out_rem      : remainder
//   out_err      : non-zero remainder, quotient overflow or zero divisor
//   out_data_vld : one-cycle result strobe
//   err_cnt      : saturating count of erroneous results
//                  (only when CHECKSUM_VERIFY_ERR_CNT_EN is defined)
module checksum_verify
    import checksum_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = checksum_pkg::IN_DATA_WIDTH,
    parameter int OUT_DATA_WIDTH = checksum_pkg::OUT_DATA_WIDTH,
    parameter int POLY_WIDTH     = checksum_pkg::POLY_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_data_vld,
    input  logic [IN_DATA_WIDTH-1:0]  in_data,
    input  logic [POLY_WIDTH-1:0]     polynomial,
    output logic                      in_ready,
    output logic [OUT_DATA_WIDTH-1:0] out_data,
    output logic [POLY_WIDTH-1:0]     out_rem,
    output logic                      out_err,
    output logic                      out_data_vld
`ifdef CHECKSUM_VERIFY_ERR_CNT_EN
    ,
    output logic [15:0]               err_cnt
`endif
);

    localparam int CNT_W = $clog2(IN_DATA_WIDTH + 1);

    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [IN_DATA_WIDTH-1:0]  dividend_q;
    logic [POLY_WIDTH-1:0]     divisor_q;
    logic [POLY_WIDTH-1:0]     rem_q;
    logic [IN_DATA_WIDTH-1:0]  quot_q;

    logic [POLY_WIDTH-1:0]     rem_d;
    logic                      q_bit;
    logic [IN_DATA_WIDTH-1:0]  quot_d;

    checksum_div_step #(
        .POLY_WIDTH(POLY_WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (dividend_q[IN_DATA_WIDTH-1]),
        .divisor_i (divisor_q),
        .rem_o     (rem_d),
        .q_o       (q_bit)
    );

    always_comb begin
        quot_d = (quot_q << 1) | IN_DATA_WIDTH'(q_bit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            in_ready     <= 1'b1;
            out_data     <= '0;
            out_rem      <= '0;
            out_err      <= 1'b0;
            out_data_vld <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_data_vld <= 1'b0;
                    if (in_data_vld) begin
                        in_ready <= 1'b0;
                        if (polynomial == '0) begin
                            state_q      <= DONE;
                            out_data     <= '1;
                            out_rem      <= '0;
                            out_err      <= 1'b1;
                            out_data_vld <= 1'b1;
                        end else begin
                            state_q    <= CALC;
                            dividend_q <= in_data;
                            divisor_q  <= polynomial;
                            rem_q      <= '0;
                            quot_q     <= '0;
                            cnt_q      <= '0;
                        end
                    end
                end
                CALC: begin
                    rem_q      <= rem_d;
                    quot_q     <= quot_d;
                    dividend_q <= dividend_q << 1;
                    cnt_q      <= cnt_q + 1'b1;
                    // Last step: publish results straight from the step output.
                    if (cnt_q == CNT_W'(IN_DATA_WIDTH - 1)) begin
                        state_q      <= DONE;
                        out_data     <= quot_d[OUT_DATA_WIDTH-1:0];
                        out_rem      <= rem_d;
                        out_err      <= (rem_d != '0) ||
                                        (quot_d[IN_DATA_WIDTH-1:OUT_DATA_WIDTH] != '0);
                        out_data_vld <= 1'b1;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    out_data_vld <= 1'b0;
                    in_ready     <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    out_data_vld <= 1'b0;
                    in_ready     <= 1'b1;
                end
            endcase
        end
    end

`ifdef CHECKSUM_VERIFY_ERR_CNT_EN
    // Counts on the edge that ends the DONE cycle of an erroneous result.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (out_data_vld && out_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_checksum_verify.sv
// tb_checksum_verify
//   Self-checking bench for checksum_verify: directed cases plus random
//   codewords checked against an arithmetic divide/modulo reference.
//   Define CHECKSUM_VERIFY_ERR_CNT_EN to also check err_cnt.
module tb_checksum_verify;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_data_vld;
    logic [20:0] in_data;
    logic [3:0]  polynomial;
    logic        in_ready;
    logic [16:0] out_data;
    logic [3:0]  out_rem;
    logic        out_err;
    logic        out_data_vld;
`ifdef CHECKSUM_VERIFY_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int exp_errs = 0;

    always #5 clk = ~clk;

    checksum_verify dut (
        .clk          (clk),
        .reset        (reset),
        .in_data_vld  (in_data_vld),
        .in_data      (in_data),
        .polynomial   (polynomial),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_rem      (out_rem),
        .out_err      (out_err),
        .out_data_vld (out_data_vld)
`ifdef CHECKSUM_VERIFY_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    // Reference: plain integer division of the codeword by the polynomial.
    task automatic ref_model(input logic [20:0] d, input logic [3:0] p,
                             output logic [16:0] q, output logic [3:0] r,
                             output logic e, output int lat);
        int unsigned quo;
        int unsigned rem;
        if (p == 0) begin
            q = 17'h1FFFF; r = 4'd0; e = 1'b1; lat = 0;
        end else begin
            quo = int'(d) / int'(p);
            rem = int'(d) % int'(p);
            q   = quo[16:0];
            r   = rem[3:0];
            e   = (rem != 0) || (quo >= 32'd131072);
            lat = 21;
        end
    endtask

    // Called and returns at #1 after a posedge.
    task automatic run_one(input string name, input logic [20:0] d, input logic [3:0] p);
        logic [16:0] eq;
        logic [3:0]  er;
        logic        ee;
        int          elat;
        int          guard;
        int          lat;
        ref_model(d, p, eq, er, ee, elat);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_timeout: in_ready=%b required 1", name, in_ready);
        end
        in_data = d; polynomial = p; in_data_vld = 1'b1;
        @(posedge clk); #1;
        in_data_vld = 1'b0;
        lat = 0;
        while (!out_data_vld && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        vectors++;
        if (lat !== elat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, elat);
        end
        vectors++;
        if ({out_data, out_rem, out_err, in_ready} !== {eq, er, ee, 1'b0}) begin
            miscompares++;
            $display("FAIL %s result: data=%0d rem=%0d err=%b rdy=%b required data=%0d rem=%0d err=%b rdy=0",
                     name, out_data, out_rem, out_err, in_ready, eq, er, ee);
        end
        if (ee) exp_errs++;
        @(posedge clk); #1;
        vectors++;
        if ({out_data_vld, in_ready, out_data, out_rem, out_err} !== {1'b0, 1'b1, eq, er, ee}) begin
            miscompares++;
            $display("FAIL %s after_done: vld=%b rdy=%b data=%0d rem=%0d err=%b required vld=0 rdy=1 held values",
                     name, out_data_vld, in_ready, out_data, out_rem, out_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_data_vld = 1'b1; in_data = 21'd5; polynomial = 4'd3;
        @(posedge clk); #1;
        vectors++;
        if ({in_ready, out_data, out_rem, out_err, out_data_vld} !== {1'b1, 17'd0, 4'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: rdy=%b data=%0d rem=%0d err=%b vld=%b required 1/0/0/0/0",
                     in_ready, out_data, out_rem, out_err, out_data_vld);
        end
        reset = 1'b0; in_data_vld = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({in_ready, out_data_vld} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_wins: rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_data_vld);
        end
    endtask

    task automatic test_directed();
        run_one("clean_codeword", 21'd1834994, 4'd14);
        run_one("corrupt", 21'd302, 4'd3);
        run_one("div_zero", 21'd55, 4'd0);
        run_one("overflow", 21'd131072, 4'd1);
        run_one("max_codeword", 21'h1FFFFF, 4'd15);
    endtask

    task automatic test_ignore_busy();
        int results = 0;
        in_data = 21'd294; polynomial = 4'd7; in_data_vld = 1'b1;
        @(posedge clk); #1;
        in_data_vld = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 5) begin
                in_data = 21'd100; polynomial = 4'd3; in_data_vld = 1'b1;
            end else begin
                in_data_vld = 1'b0;
            end
            @(posedge clk); #1;
            if (out_data_vld) results++;
        end
        in_data_vld = 1'b0;
        vectors++;
        if (results !== 1) begin
            miscompares++;
            $display("FAIL ignore_busy: got %0d results required 1", results);
        end
        vectors++;
        if ({out_data, out_err} !== {17'd42, 1'b0}) begin
            miscompares++;
            $display("FAIL ignore_busy_data: data=%0d err=%b required 42/0", out_data, out_err);
        end
        run_one("accept_after_idle", 21'd100, 4'd3);
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        in_data = 21'd1834994; polynomial = 4'd14; in_data_vld = 1'b1;
        @(posedge clk); #1;
        in_data_vld = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_errs = 0;
        vectors++;
        if ({in_ready, out_data, out_rem, out_err, out_data_vld} !== {1'b1, 17'd0, 4'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid: rdy=%b data=%0d rem=%0d err=%b vld=%b required 1/0/0/0/0",
                     in_ready, out_data, out_rem, out_err, out_data_vld);
        end
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_data_vld) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_strobe: got %0d strobes required 0", stray);
        end
        run_one("after_reset", 21'd294, 4'd7);
    endtask

    task automatic test_random();
        logic [20:0] d;
        logic [3:0]  p;
        for (int i = 0; i < 40; i++) begin
            p = 4'($urandom_range(0, 15));
            if ((i % 2) == 0 && p != 0)
                d = 21'($urandom_range(0, 131071) * p);
            else
                d = 21'($urandom_range(0, 2097151));
            run_one("random", d, p);
        end
    endtask

    task automatic test_err_cnt();
`ifdef CHECKSUM_VERIFY_ERR_CNT_EN
        @(posedge clk); #1;
        vectors++;
        if (err_cnt !== 16'(exp_errs)) begin
            miscompares++;
            $display("FAIL err_cnt: got %0d required %0d", err_cnt, exp_errs);
        end
`endif
    endtask

    initial begin
        reset = 1'b1; in_data_vld = 1'b0; in_data = '0; polynomial = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        test_err_cnt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
